// File: rtl/router_pkt_fifo_pkg.sv
// Shared definitions for the packet-aware router FIFO: header field layout and tracker states.
package router_pkg;

  localparam int unsigned HDR_ADDR_W  = 2;
  localparam int unsigned HDR_LEN_LSB = HDR_ADDR_W;

  typedef enum logic {
    IDLE,
    PAYLOAD
  } trk_state_t;

endpackage

// File: rtl/router_pkt_fifo_tracker.sv
// Read-side packet tracker: follows header/payload/parity boundaries of words leaving the FIFO.
// Optional running-XOR parity check enabled by ROUTER_FIFO_PARITY_CHK_EN.
module router_fifo_pkt_tracker
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_soft_rst,
  input  logic              i_rd_acc,
  input  logic              i_tag,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_pkt_busy,
  output logic              o_pkt_done,
  output logic              o_parity_err
);

  localparam int unsigned LEN_W = DATA_W - HDR_LEN_LSB;
  localparam int unsigned CNT_W = LEN_W + 1;

  trk_state_t       r_state;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic             r_pkt_busy;
  logic             r_pkt_done;

  logic [LEN_W-1:0] w_len;
  logic             w_hdr_load;
  logic             w_pay;
  logic             w_last;

  assign w_len      = i_data[DATA_W-1:HDR_LEN_LSB];
  assign w_hdr_load = i_rd_acc & i_tag;
  assign w_pay      = i_rd_acc & ~i_tag & (r_state == PAYLOAD);
  assign w_last     = w_pay & (r_pkt_cnt == CNT_W'(1));

  // A tagged word always (re)starts a packet, so a truncated packet is silently replaced.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_pkt_cnt  <= '0;
      r_pkt_busy <= 1'b0;
      r_pkt_done <= 1'b0;
    end else if (i_soft_rst) begin
      r_state    <= IDLE;
      r_pkt_cnt  <= '0;
      r_pkt_busy <= 1'b0;
      r_pkt_done <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      if (w_hdr_load) begin
        r_state    <= PAYLOAD;
        r_pkt_cnt  <= {1'b0, w_len} + CNT_W'(1);
        r_pkt_busy <= 1'b1;
      end else begin
        case (r_state)
          PAYLOAD: begin
            if (w_pay) begin
              r_pkt_cnt <= r_pkt_cnt - CNT_W'(1);
              if (w_last) begin
                r_state    <= IDLE;
                r_pkt_busy <= 1'b0;
                r_pkt_done <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_pkt_busy = r_pkt_busy;
  assign o_pkt_done = r_pkt_done;

`ifdef ROUTER_FIFO_PARITY_CHK_EN
  logic [DATA_W-1:0] r_xor;
  logic              r_parity_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_xor        <= '0;
      r_parity_err <= 1'b0;
    end else if (i_soft_rst) begin
      r_xor        <= '0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      if (w_hdr_load) begin
        r_xor <= i_data;
      end else if (w_last) begin
        r_parity_err <= (r_xor != i_data);
      end else if (w_pay) begin
        r_xor <= r_xor ^ i_data;
      end
    end
  end

  assign o_parity_err = r_parity_err;
`else
  logic w_unused_addr;
  assign w_unused_addr = ^i_data[HDR_LEN_LSB-1:0];
  assign o_parity_err  = 1'b0;
`endif

endmodule

// File: rtl/router_pkt_fifo.sv
// Per-output-port packet FIFO: tagged storage, occupancy flags, registered read port, packet tracker.
// Define ROUTER_FIFO_PARITY_CHK_EN to enable the read-side parity check.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     soft_rst,
  input  logic                     wr_en,
  input  logic                     lfd_state,
  input  logic [DATA_W-1:0]        din,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_hdr,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pkt_busy,
  output logic                     pkt_done,
  output logic                     parity_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W:0]   r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_hdr;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W:0]   w_rd_word;

  // Flags come from the pre-edge count, so full blocks a write even alongside a read.
  assign w_wr_acc  = wr_en & ~full  & ~soft_rst;
  assign w_rd_acc  = rd_en & ~empty & ~soft_rst;
  assign w_rd_word = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= {lfd_state, din};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_dout     <= '0;
      r_dout_hdr <= 1'b0;
    end else if (soft_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_dout     <= '0;
      r_dout_hdr <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_dout     <= w_rd_word[DATA_W-1:0];
        r_dout_hdr <= w_rd_word[DATA_W];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign full        = (r_count == CW'(DEPTH));
  assign empty       = (r_count == '0);
  assign almost_full = (r_count >= CW'(DEPTH - AF_MARGIN));
  assign count       = r_count;
  assign dout        = r_dout;
  assign dout_hdr    = r_dout_hdr;

  router_fifo_pkt_tracker #(
    .DATA_W(DATA_W)
  ) u_tracker (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_soft_rst  (soft_rst),
    .i_rd_acc    (w_rd_acc),
    .i_tag       (w_rd_word[DATA_W]),
    .i_data      (w_rd_word[DATA_W-1:0]),
    .o_pkt_busy  (pkt_busy),
    .o_pkt_done  (pkt_done),
    .o_parity_err(parity_err)
  );

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Self-checking bench for router_pkt_fifo: directed table, corner sequences, random traffic vs a queue model.
module tb_router_pkt_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;
`ifdef ROUTER_FIFO_PARITY_CHK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, soft_rst, wr_en, lfd_state, rd_en;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          dout_hdr, full, empty, almost_full, pkt_busy, pkt_done, parity_err;
  logic [4:0]    count;

  always #5 clk = ~clk;

  router_pkt_fifo #(
    .DATA_W(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM)
  ) dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .wr_en(wr_en), .lfd_state(lfd_state),
    .din(din), .rd_en(rd_en), .dout(dout), .dout_hdr(dout_hdr), .full(full),
    .empty(empty), .almost_full(almost_full), .count(count), .pkt_busy(pkt_busy),
    .pkt_done(pkt_done), .parity_err(parity_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of {tag,data} plus "words left in current packet".
  logic [8:0] mq[$];
  logic [7:0] m_dout, m_xor;
  bit         m_hdr, m_busy, m_done, m_perr;
  int         m_rem;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_dout = '0; m_xor = '0; m_hdr = 0; m_busy = 0; m_done = 0; m_perr = 0; m_rem = 0;
  endtask

  task automatic model_edge();
    bit         wr_ok, rd_ok;
    logic [8:0] w;
    if (soft_rst) begin
      model_clear();
    end else begin
      wr_ok  = wr_en && (mq.size() < DEPTH);
      rd_ok  = rd_en && (mq.size() > 0);
      m_done = 0;
      m_perr = 0;
      if (rd_ok) begin
        w      = mq.pop_front();
        m_dout = w[7:0];
        m_hdr  = w[8];
        if (w[8]) begin
          m_rem  = int'(w[7:2]) + 1;
          m_busy = 1;
          m_xor  = w[7:0];
        end else if (m_busy) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_busy = 0;
            m_done = 1;
            m_perr = PAR_EN && (m_xor != w[7:0]);
          end else begin
            m_xor = m_xor ^ w[7:0];
          end
        end
      end
      if (wr_ok) mq.push_back({lfd_state, din});
    end
  endtask

  task automatic compare_all();
    chk("count",       32'(count),       32'(mq.size()));
    chk("empty",       32'(empty),       32'(mq.size() == 0));
    chk("full",        32'(full),        32'(mq.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH - AFM));
    chk("dout",        32'(dout),        32'(m_dout));
    chk("dout_hdr",    32'(dout_hdr),    32'(m_hdr));
    chk("pkt_busy",    32'(pkt_busy),    32'(m_busy));
    chk("pkt_done",    32'(pkt_done),    32'(m_done));
    chk("parity_err",  32'(parity_err),  32'(m_perr));
  endtask

  task automatic cycle(input bit w, input bit h, input logic [7:0] d, input bit r, input bit s);
    wr_en = w; lfd_state = h; din = d; rd_en = r; soft_rst = s;
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  typedef struct {
    bit         wr;
    bit         hdr;
    logic [7:0] d;
    bit         rd;
    int         exp_count;
    bit         exp_empty;
    logic [7:0] exp_dout;
    bit         exp_hdr;
    bit         exp_busy;
    bit         exp_done;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] last;
    int         rem_w;
    bit         w, h, r, s;
    logic [7:0] d;

    rst = 1; soft_rst = 0; wr_en = 0; lfd_state = 0; din = '0; rd_en = 0;
    model_clear();
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_dout",  32'(dout),  32'd0);
    chk("rst_busy",  32'(pkt_busy), 32'd0);
    @(negedge clk); rst = 0;

    // Packet hdr 0D (len 3, addr 1), payload 11/22/33, parity 0D (correct XOR).
    tbl[0]  = '{1, 1, 8'h0D, 0, 1, 0, 8'h00, 0, 0, 0};
    tbl[1]  = '{1, 0, 8'h11, 0, 2, 0, 8'h00, 0, 0, 0};
    tbl[2]  = '{1, 0, 8'h22, 0, 3, 0, 8'h00, 0, 0, 0};
    tbl[3]  = '{1, 0, 8'h33, 0, 4, 0, 8'h00, 0, 0, 0};
    tbl[4]  = '{1, 0, 8'h0D, 0, 5, 0, 8'h00, 0, 0, 0};
    tbl[5]  = '{0, 0, 8'h00, 1, 4, 0, 8'h0D, 1, 1, 0};
    tbl[6]  = '{0, 0, 8'h00, 1, 3, 0, 8'h11, 0, 1, 0};
    tbl[7]  = '{0, 0, 8'h00, 1, 2, 0, 8'h22, 0, 1, 0};
    tbl[8]  = '{0, 0, 8'h00, 1, 1, 0, 8'h33, 0, 1, 0};
    tbl[9]  = '{0, 0, 8'h00, 1, 0, 1, 8'h0D, 0, 0, 1};
    tbl[10] = '{0, 0, 8'h00, 0, 0, 1, 8'h0D, 0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].wr, tbl[i].hdr, tbl[i].d, tbl[i].rd, 1'b0);
      chk($sformatf("tbl%0d_count", i), 32'(count),    32'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_empty", i), 32'(empty),    32'(tbl[i].exp_empty));
      chk($sformatf("tbl%0d_dout", i),  32'(dout),     32'(tbl[i].exp_dout));
      chk($sformatf("tbl%0d_hdr", i),   32'(dout_hdr), 32'(tbl[i].exp_hdr));
      chk($sformatf("tbl%0d_busy", i),  32'(pkt_busy), 32'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_done", i),  32'(pkt_done), 32'(tbl[i].exp_done));
      chk($sformatf("tbl%0d_perr", i),  32'(parity_err), 32'd0);
    end

    // Async reset mid-packet, asserted between clock edges.
    cycle(1, 1, 8'h0C, 0, 0);
    cycle(1, 0, 8'h44, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    chk("pre_rst_busy", 32'(pkt_busy), 32'd1);
    #2 rst = 1;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_dout",  32'(dout),  32'd0);
    chk("arst_busy",  32'(pkt_busy), 32'd0);
    model_clear();
    wr_en = 0; rd_en = 0;
    @(negedge clk); @(negedge clk); rst = 0;

    // Fill to full, 17th write dropped, read back in order.
    for (int i = 0; i < 17; i++) begin
      cycle(1, 0, 8'(i + 1), 0, 0);
      if (i == 12) chk("af_at13", 32'(almost_full), 32'd0);
      if (i == 13) chk("af_at14", 32'(almost_full), 32'd1);
    end
    chk("full16", 32'(full), 32'd1);
    chk("count16", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 8'h00, 1, 0);
      chk("order", 32'(dout), 32'(i + 1));
    end
    chk("drained_empty", 32'(empty), 32'd1);

    // Simultaneous read+write at full and at empty.
    for (int i = 0; i < 16; i++) cycle(1, 0, 8'(8'h80 + i), 0, 0);
    cycle(1, 0, 8'hAA, 1, 0);
    chk("full_rw_count", 32'(count), 32'd15);
    chk("full_rw_dout",  32'(dout),  32'h80);
    for (int i = 0; i < 15; i++) cycle(0, 0, 8'h00, 1, 0);
    last = dout;
    chk("last_drained", 32'(last), 32'h8F);
    cycle(1, 0, 8'hBB, 1, 0);
    chk("empty_rw_count", 32'(count), 32'd1);
    chk("empty_rw_dout",  32'(dout),  32'(last));
    cycle(0, 0, 8'h00, 1, 0);
    chk("empty_rw_data", 32'(dout), 32'hBB);

    // Soft reset mid-packet discards a same-cycle write.
    cycle(1, 1, 8'h08, 0, 0);
    cycle(1, 0, 8'h01, 0, 0);
    cycle(1, 0, 8'h02, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    chk("sr_pre_busy", 32'(pkt_busy), 32'd1);
    cycle(1, 0, 8'h55, 0, 1);
    chk("sr_empty", 32'(empty), 32'd1);
    chk("sr_busy",  32'(pkt_busy), 32'd0);
    chk("sr_dout",  32'(dout), 32'd0);
    cycle(0, 0, 8'h00, 0, 0);
    chk("sr_wr_ignored", 32'(count), 32'd0);

    // Parity: wrong parity then correct parity on a len-1 packet; then len-0 packet.
    cycle(1, 1, 8'h04, 0, 0);
    cycle(1, 0, 8'h5A, 0, 0);
    cycle(1, 0, 8'h00, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(0, 0, 8'h00, 1, 0);
    cycle(0, 0, 8'h00, 1, 0);
    chk("bad_par_done", 32'(pkt_done), 32'd1);
    chk("bad_par_err",  32'(parity_err), 32'(PAR_EN));
    cycle(1, 1, 8'h04, 0, 0);
    cycle(1, 0, 8'h5A, 0, 0);
    cycle(1, 0, 8'h5E, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1, 0);
    chk("good_par_done", 32'(pkt_done), 32'd1);
    chk("good_par_err",  32'(parity_err), 32'd0);
    cycle(1, 1, 8'h02, 0, 0);
    cycle(1, 0, 8'h02, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    chk("len0_busy", 32'(pkt_busy), 32'd1);
    cycle(0, 0, 8'h00, 1, 0);
    chk("len0_done", 32'(pkt_done), 32'd1);
    chk("len0_idle", 32'(pkt_busy), 32'd0);

    // Random traffic against the model.
    rem_w = 0;
    for (int i = 0; i < 800; i++) begin
      w = ($urandom % 3) != 0;
      r = ($urandom % 2) != 0;
      s = ($urandom % 100) == 0;
      if (rem_w == 0 || ($urandom % 40) == 0) begin
        h = 1;
        d = {6'($urandom_range(0, 3)), 2'($urandom % 4)};
      end else begin
        h = 0;
        d = 8'($urandom);
      end
      if (w && !s && mq.size() < DEPTH) rem_w = h ? int'(d[7:2]) + 1 : rem_w - 1;
      if (s) rem_w = 0;
      cycle(w, h, d, r, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
